// File: rtl/lut_access_ctrl_pkg.sv
// Shared defaults and types for the LUT access controller.
// Read latency constant and in-flight stage record used by the top.
package lut_access_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_LINES = 4;
  localparam int RD_LATENCY     = 2;

  typedef logic rid_t;

  localparam rid_t RID0 = 1'b0;
  localparam rid_t RID1 = 1'b1;

  typedef struct packed {
    logic vld;
    rid_t id;
  } stage_t;

endpackage

// File: rtl/lut_access_ctrl_ram.sv
// Table RAM: one write port, one registered read port plus a resettable output register.
// Latency 2 (read register, then output register); no backpressure.
module dual_port_ram #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  input  logic          i_oe,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rd;
  logic [DW-1:0] r_dout;

  // Array and read register are not reset so table contents survive a reset.
  always_ff @(posedge clk_i) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rd <= r_mem[i_raddr];
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i)   r_dout <= '0;
    else if (i_oe) r_dout <= r_rd;
  end

  assign o_rdata = r_dout;

endmodule

// File: rtl/lut_access_ctrl.sv
// Two-requester round-robin read arbiter over a loadable table RAM; write-collision reads deferred a cycle.
// Read latency 2 from grant, one read per cycle; requesters hold req until the combinational grant.
module lut_access_ctrl
  import lut_access_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_LINES = DEF_ADDR_LINES
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [ADDR_LINES-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd0_req_i,
  input  logic                  rd1_req_i,
  input  logic [ADDR_LINES-1:0] rd0_addr_i,
  input  logic [ADDR_LINES-1:0] rd1_addr_i,
  output logic                  rd0_gnt_o,
  output logic                  rd1_gnt_o,
  output logic                  rd_valid_o,
  output logic                  rd_id_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  idle_o
);

  logic   r_wr_ready;
  rid_t   r_ptr;
  stage_t r_pipe [RD_LATENCY];

  logic                  w_wr_acc;
  logic                  w_cand0;
  logic                  w_cand1;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_any_gnt;
  logic [ADDR_LINES-1:0] w_rd_addr;
  logic                  w_inflight;

  assign w_wr_acc = wr_valid_i & r_wr_ready;

  // A read hitting the address being written this cycle waits one cycle so it sees the new data.
  assign w_cand0 = rstn_i & rd0_req_i & ~(w_wr_acc & (rd0_addr_i == wr_addr_i));
  assign w_cand1 = rstn_i & rd1_req_i & ~(w_wr_acc & (rd1_addr_i == wr_addr_i));

  assign w_gnt0    = w_cand0 & (~w_cand1 | (r_ptr == RID0));
  assign w_gnt1    = w_cand1 & (~w_cand0 | (r_ptr == RID1));
  assign w_any_gnt = w_gnt0 | w_gnt1;
  assign w_rd_addr = w_gnt1 ? rd1_addr_i : rd0_addr_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_wr_ready <= 1'b0;
      r_ptr      <= RID0;
    end else begin
      r_wr_ready <= 1'b1;
      if (w_gnt0)      r_ptr <= RID1;
      else if (w_gnt1) r_ptr <= RID0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < RD_LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= '{vld: w_any_gnt, id: w_gnt1 ? RID1 : RID0};
      for (int i = 1; i < RD_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_comb begin
    w_inflight = 1'b0;
    for (int i = 0; i < RD_LATENCY; i++) w_inflight = w_inflight | r_pipe[i].vld;
  end

  dual_port_ram #(
    .DW (DATA_WIDTH),
    .AW (ADDR_LINES)
  ) u_ram (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .i_we    (w_wr_acc),
    .i_waddr (wr_addr_i),
    .i_wdata (wr_data_i),
    .i_re    (w_any_gnt),
    .i_raddr (w_rd_addr),
    .i_oe    (r_pipe[0].vld),
    .o_rdata (rd_data_o)
  );

  assign wr_ready_o = r_wr_ready;
  assign rd0_gnt_o  = w_gnt0;
  assign rd1_gnt_o  = w_gnt1;
  assign rd_valid_o = r_pipe[RD_LATENCY-1].vld;
  assign rd_id_o    = r_pipe[RD_LATENCY-1].id;
  assign idle_o     = ~(w_inflight | rd0_req_i | rd1_req_i);

endmodule

// File: tb/tb_lut_access_ctrl.sv
// Directed bench for lut_access_ctrl: hand-computed grants, ids, data and idle per cycle.
module tb_lut_access_ctrl;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [3:0]  wr_addr_i;
  logic [31:0] wr_data_i;
  logic        rd0_req_i, rd1_req_i;
  logic [3:0]  rd0_addr_i, rd1_addr_i;
  logic        rd0_gnt_o, rd1_gnt_o;
  logic        rd_valid_o;
  logic        rd_id_o;
  logic [31:0] rd_data_o;
  logic        idle_o;

  int n_chk = 0;
  int n_err = 0;

  lut_access_ctrl #(.DATA_WIDTH(32), .ADDR_LINES(4)) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .wr_valid_i (wr_valid_i),
    .wr_ready_o (wr_ready_o),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .rd0_req_i  (rd0_req_i),
    .rd1_req_i  (rd1_req_i),
    .rd0_addr_i (rd0_addr_i),
    .rd1_addr_i (rd1_addr_i),
    .rd0_gnt_o  (rd0_gnt_o),
    .rd1_gnt_o  (rd1_gnt_o),
    .rd_valid_o (rd_valid_o),
    .rd_id_o    (rd_id_o),
    .rd_data_o  (rd_data_o),
    .idle_o     (idle_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow after #1.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_valid_i = 1'b1;
    wr_addr_i  = a;
    wr_data_i  = d;
    tick();
    wr_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout n_chk=%0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    rstn_i = 1'b0; wr_valid_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    rd0_req_i = 1'b0; rd1_req_i = 1'b0; rd0_addr_i = '0; rd1_addr_i = '0;
    tick(); tick();

    // Reset state; a request during reset must not be granted.
    rd0_req_i = 1'b1;
    #1;
    chk("rst_wr_ready", wr_ready_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_rd_id",    rd_id_o,    0);
    chk("rst_rd_data",  rd_data_o,  0);
    chk("rst_no_gnt",   {rd0_gnt_o, rd1_gnt_o}, 2'b00);
    chk("rst_idle_req", idle_o, 0);
    rd0_req_i = 1'b0;
    #1;
    chk("rst_idle", idle_o, 1);
    rstn_i = 1'b1;
    tick();
    chk("wr_ready_up", wr_ready_o, 1);

    wr(4'd3, 32'hDEADBEEF);
    wr(4'd1, 32'h1111);
    wr(4'd2, 32'h2222);
    wr(4'd5, 32'h22);
    wr(4'd6, 32'h66);

    // Single read of addr 3 by rd0.
    rd0_req_i = 1'b1; rd0_addr_i = 4'd3;
    #1;
    chk("t1_gnt", {rd0_gnt_o, rd1_gnt_o}, 2'b10);
    tick();
    rd0_req_i = 1'b0;
    #1;
    chk("t1_n1_valid", rd_valid_o, 0);
    tick();
    chk("t1_valid", rd_valid_o, 1);
    chk("t1_id",    rd_id_o,    0);
    chk("t1_data",  rd_data_o,  32'hDEADBEEF);
    tick();
    chk("t1_valid_drop", rd_valid_o, 0);
    chk("t1_data_hold",  rd_data_o,  32'hDEADBEEF);

    // rd1 alone for two cycles: granted back-to-back; pointer ends favouring rd0.
    rd1_req_i = 1'b1; rd1_addr_i = 4'd2;
    #1;
    chk("solo_gnt_a", {rd0_gnt_o, rd1_gnt_o}, 2'b01);
    tick();
    #1;
    chk("solo_gnt_b", {rd0_gnt_o, rd1_gnt_o}, 2'b01);
    tick();
    rd1_req_i = 1'b0;
    tick(); tick(); tick();

    // Both requesting for 6 cycles, then 5 quiet cycles to observe drain and idle.
    rd0_addr_i = 4'd1; rd1_addr_i = 4'd2;
    for (int c = 0; c < 11; c++) begin
      rd0_req_i = (c < 6);
      rd1_req_i = (c < 6);
      #1;
      chk($sformatf("rr_gnt_c%0d", c), {rd0_gnt_o, rd1_gnt_o},
          (c < 6) ? ((c % 2 == 0) ? 2'b10 : 2'b01) : 2'b00);
      chk($sformatf("rr_valid_c%0d", c), rd_valid_o, (c >= 2 && c < 8));
      if (c >= 2 && c < 8) begin
        chk($sformatf("rr_id_c%0d", c), rd_id_o, (c - 2) % 2);
        chk($sformatf("rr_data_c%0d", c), rd_data_o, ((c - 2) % 2 == 0) ? 32'h1111 : 32'h2222);
      end
      if (c >= 8) chk($sformatf("rr_data_hold_c%0d", c), rd_data_o, 32'h2222);
      chk($sformatf("rr_idle_c%0d", c), idle_o, (c >= 8));
      tick();
    end

    // Write addr 5 while rd1 reads addr 5: deferred one cycle, returns new data.
    wr_valid_i = 1'b1; wr_addr_i = 4'd5; wr_data_i = 32'h11;
    rd1_req_i = 1'b1; rd1_addr_i = 4'd5;
    #1;
    chk("col_blocked", {rd0_gnt_o, rd1_gnt_o}, 2'b00);
    tick();
    wr_valid_i = 1'b0;
    #1;
    chk("col_next_gnt", {rd0_gnt_o, rd1_gnt_o}, 2'b01);
    tick();
    rd1_req_i = 1'b0;
    tick();
    chk("col_valid", rd_valid_o, 1);
    chk("col_id",    rd_id_o,    1);
    chk("col_data",  rd_data_o,  32'h11);
    tick();
    wr(4'd5, 32'h22);

    // Same collision with rd0 on addr 6: rd0 goes first, rd1 follows.
    wr_valid_i = 1'b1; wr_addr_i = 4'd5; wr_data_i = 32'h33;
    rd0_req_i = 1'b1; rd0_addr_i = 4'd6;
    rd1_req_i = 1'b1; rd1_addr_i = 4'd5;
    #1;
    chk("col2_gnt0", {rd0_gnt_o, rd1_gnt_o}, 2'b10);
    tick();
    wr_valid_i = 1'b0; rd0_req_i = 1'b0;
    #1;
    chk("col2_gnt1", {rd0_gnt_o, rd1_gnt_o}, 2'b01);
    tick();
    rd1_req_i = 1'b0;
    #1;
    chk("col2_v0",    rd_valid_o, 1);
    chk("col2_id0",   rd_id_o,    0);
    chk("col2_data0", rd_data_o,  32'h66);
    tick();
    chk("col2_v1",    rd_valid_o, 1);
    chk("col2_id1",   rd_id_o,    1);
    chk("col2_data1", rd_data_o,  32'h33);
    rd0_req_i = 1'b1; rd1_req_i = 1'b1; rd0_addr_i = 4'd1; rd1_addr_i = 4'd2;
    #1;
    chk("col2_ptr_a", {rd0_gnt_o, rd1_gnt_o}, 2'b10);
    tick();
    #1;
    chk("col2_ptr_b", {rd0_gnt_o, rd1_gnt_o}, 2'b01);
    tick();
    rd0_req_i = 1'b0; rd1_req_i = 1'b0;
    tick(); tick(); tick();

    // Two back-to-back grants (rd1 then rd0, pointer left on rd1), then reset.
    rd1_req_i = 1'b1; rd1_addr_i = 4'd2;
    #1;
    chk("pre_rst_g1", {rd0_gnt_o, rd1_gnt_o}, 2'b01);
    tick();
    rd1_req_i = 1'b0; rd0_req_i = 1'b1; rd0_addr_i = 4'd3;
    #1;
    chk("pre_rst_g0", {rd0_gnt_o, rd1_gnt_o}, 2'b10);
    tick();
    rstn_i = 1'b0;
    #1;
    chk("in_rst_no_gnt", {rd0_gnt_o, rd1_gnt_o}, 2'b00);
    tick();
    rstn_i = 1'b1; rd0_req_i = 1'b0;
    #1;
    chk("post_rst_valid_a", rd_valid_o, 0);
    chk("post_rst_data",    rd_data_o,  0);
    chk("post_rst_ready_a", wr_ready_o, 0);
    tick();
    chk("post_rst_valid_b", rd_valid_o, 0);
    chk("post_rst_ready_b", wr_ready_o, 1);
    rd0_req_i = 1'b1; rd0_addr_i = 4'd3;
    rd1_req_i = 1'b1; rd1_addr_i = 4'd1;
    #1;
    chk("post_rst_ptr", {rd0_gnt_o, rd1_gnt_o}, 2'b10);
    chk("post_rst_valid_c", rd_valid_o, 0);
    tick();
    rd0_req_i = 1'b0;
    #1;
    chk("post_rst_g1", {rd0_gnt_o, rd1_gnt_o}, 2'b01);
    tick();
    rd1_req_i = 1'b0;
    #1;
    chk("post_rst_v0",    rd_valid_o, 1);
    chk("post_rst_id0",   rd_id_o,    0);
    chk("post_rst_data0", rd_data_o,  32'hDEADBEEF);
    tick();
    chk("post_rst_v1",    rd_valid_o, 1);
    chk("post_rst_id1",   rd_id_o,    1);
    chk("post_rst_data1", rd_data_o,  32'h1111);
    tick();
    chk("post_rst_vdrop", rd_valid_o, 0);
    tick();
    chk("post_rst_idle",  idle_o,     1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
